i2s_sample_transmitter: RTL and testbench
=========================================

// Module: i2s_sample_transmitter
// PURPOSE
//  Consumer end of the synthesizer sample stream: accepts signed 16-bit mono samples
//  (Synthesizer .out) via valid/ready, buffers them in a small FIFO, and serialises
//  each one as a stereo I2S frame (same word on L and R) toward the board audio DAC.
//  Frame rate = clk / (2*BCLK_DIV*32); the upstream rate must not exceed this.
// PARAMETERS
//  SAMPLE_WIDTH  16  bits per channel word; frame = 2*SAMPLE_WIDTH bclk periods
//  BCLK_DIV      4   clk cycles per bclk half-period (>=1)
//  FIFO_DEPTH    4   sample FIFO entries (power of two, >=2)
// PORTS
//  clk           in   1    system clock, only clock domain
//  reset_n       in   1    asynchronous, active-low reset
//  enable        in   1    1 = run serial clocks; 0 = idle outputs, FIFO retained
//  sample_in     in   16   signed two's-complement sample
//  sample_valid  in   1    sample_in valid this cycle
//  sample_ready  out  1    FIFO not full; push when valid && ready
//  i2s_bclk      out  1    bit clock
//  i2s_lrck      out  1    word select: 0 = left, 1 = right
//  i2s_sdata     out  1    serial data, MSB first, changes on bclk falling edge
//  underrun      out  1    1-clk pulse: frame started with FIFO empty
// BEHAVIOUR
//  Reset: bclk=0, lrck=0, sdata=0, underrun=0, FIFO empty (sample_ready=1),
//   div_cnt=0, pos=0, cur_word=0. All outputs registered.
//  Divider: div_cnt counts 0..BCLK_DIV-1 while enable=1; at wrap bclk toggles.
//   Toggle 1->0 is a "fall event": pos advances pos+1 mod 32 (5-bit wrap 31->0).
//  Outputs updated on each fall event using the new pos:
//   lrck  = pos[4];  sdata = cur_word[15 - ((pos-1) mod 16)]  (I2S 1-bit delay:
//   MSB of each channel appears one bclk after lrck edge; LSB of R at pos=0).
//  Frame load: on the fall event entering pos=1, before sdata is computed,
//   FIFO non-empty -> pop head into cur_word; empty -> cur_word=0, underrun=1 for
//   one clk. R half (pos 17..31,0) reuses cur_word; no second pop.
//  FIFO: push when sample_valid && sample_ready; pop only at frame load.
//   Push and pop in same clk: both take effect, count unchanged. No bypass: a push
//   into an empty FIFO in the pop cycle does not serve that frame (underrun fires).
//   Full: sample_ready=0 same cycle count reaches FIFO_DEPTH; returns 1 in the clk
//   after a pop. Pointers wrap modulo FIFO_DEPTH.
//  enable=0: div_cnt=0, pos=0, bclk=0, lrck=0, sdata=0, cur_word held, no pops, no
//   underrun; pushes still accepted. Re-enable: first fall event -> pos=1 -> load.
//  reset_n low mid-frame: immediate return to reset values; FIFO contents dropped.
//  Widths: sample stored verbatim; no scaling or saturation.
// STRUCTURE
//  Package audio_pkg: typedef logic signed [15:0] sample_t;
//   localparam FRAME_BITS=32.
//  Sub-module sample_fifo (depth/width params, push/pop/full/empty/count) feeds a
//   top-level divider + pos counter + output register block.
// TESTING (BCLK_DIV=2: bclk period 4 clk, frame 128 clk)
//  Reset: assert reset_n=0 mid-frame -> all outputs 0, sample_ready=1 within 0 clk.
//  Push 16'h8001 then enable -> lrck 0 for pos 0..15; serial L bits
//   1000_0000_0000_0001, R bits identical; lrck rises 64 clk after frame start.
//  Push 16'h7FFF,16'hA5A5,16'h0000,16'hFFFF -> ready=0 after 4th push; frames
//   replay in order; ready=1 one clk after first pop.
//  No samples, enable=1 -> underrun pulse once per frame (every 128 clk), sdata=0.
//  Push coincident with frame load on empty FIFO -> underrun=1, sample sent next frame.
//  Drop enable mid-R-word, hold 50 clk, restore -> outputs 0 while low, FIFO count
//   unchanged, next frame starts at pos=1 with next queued sample.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types for the synthesizer output path.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int FRAME_BITS = 32;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO that buffers mono samples ahead of the I2S serialiser.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [COUNT_W-1:0] count;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == COUNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // NOTE: the storage array is deliberately left out of reset; empty/count gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + COUNT_W'(do_push) - COUNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/i2s_sample_transmitter.sv
// Buffers mono samples and serialises each as a stereo I2S frame (same word on L and R).
module i2s_sample_transmitter
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = $bits(sample_t),
  parameter int BCLK_DIV     = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    i2s_bclk,
  output logic                    i2s_lrck,
  output logic                    i2s_sdata,
  output logic                    underrun
);

  localparam int POS_W = $clog2(2 * SAMPLE_WIDTH);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]        div_cnt;
  logic [POS_W-1:0]        pos;
  logic [POS_W-1:0]        pos_next;
  logic [SAMPLE_WIDTH-1:0] cur_word;
  logic [SAMPLE_WIDTH-1:0] head;
  logic [SAMPLE_WIDTH-1:0] load_word;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    div_wrap;
  logic                    fall;
  logic                    load;
  logic                    pop;

  assign sample_ready = !fifo_full;

  sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (sample_valid && sample_ready),
    .push_data (sample_in),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    div_wrap  = (div_cnt == DIV_W'(BCLK_DIV - 1));
    fall      = enable && div_wrap && i2s_bclk;
    pos_next  = pos + 1'b1;
    load      = fall && (pos_next == POS_W'(1));
    pop       = load && !fifo_empty;
    load_word = cur_word;
    if (load) load_word = pop ? head : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      pos       <= '0;
      cur_word  <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else if (!enable) begin
      div_cnt   <= '0;
      pos       <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= load && fifo_empty;
      div_cnt  <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) i2s_bclk <= !i2s_bclk;
      if (fall) begin
        pos      <= pos_next;
        i2s_lrck <= pos_next[POS_W-1];
        // Old pos is (new pos - 1); inverting its channel bits gives SAMPLE_WIDTH-1-k, MSB first.
        i2s_sdata <= load_word[~pos[POS_W-2:0]];
      end
      if (load) cur_word <= load_word;
    end
  end

endmodule

// File: tb/tb_i2s_sample_transmitter.sv
// Randomised and directed bench for i2s_sample_transmitter against a timing-arithmetic reference model.
module tb_i2s_sample_transmitter;

  localparam int SW    = 16;
  localparam int DIV   = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 32 * 2 * DIV;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          i2s_bclk;
  logic          i2s_lrck;
  logic          i2s_sdata;
  logic          underrun;

  i2s_sample_transmitter #(
    .SAMPLE_WIDTH (SW),
    .BCLK_DIV     (DIV),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: t = clocks elapsed with enable high, queue = FIFO contents.
  logic [SW-1:0] q[$];
  int            t = 0;
  logic [SW-1:0] cur = '0;
  logic          exp_bclk = 1'b0;
  logic          exp_lrck = 1'b0;
  logic          exp_sdata = 1'b0;
  logic          exp_underrun = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    t = 0;
    cur = '0;
    exp_bclk = 1'b0;
    exp_lrck = 1'b0;
    exp_sdata = 1'b0;
    exp_underrun = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic v, input logic [SW-1:0] d);
    bit was_empty;
    bit can_push;
    int pos;
    was_empty = (q.size() == 0);
    can_push  = v && (q.size() < DEPTH);
    exp_underrun = 1'b0;
    if (!en) begin
      t = 0;
      exp_bclk = 1'b0;
      exp_lrck = 1'b0;
      exp_sdata = 1'b0;
    end else begin
      t++;
      exp_bclk = ((t / DIV) % 2) == 1;
      if (t % (2 * DIV) == 0) begin
        pos = (t / (2 * DIV)) % 32;
        if (pos == 1) begin
          if (was_empty) begin
            cur = '0;
            exp_underrun = 1'b1;
          end else begin
            cur = q.pop_front();
          end
        end
        exp_lrck  = (pos >= 16);
        exp_sdata = cur[15 - (((pos + 31) % 32) % 16)];
      end
    end
    if (can_push) q.push_back(d);
  endtask

  task automatic step(input logic en, input logic v, input logic [SW-1:0] d);
    enable = en;
    sample_valid = v;
    sample_in = d;
    @(posedge clk);
    model_edge(en, v, d);
    #1;
    check("bclk", i2s_bclk, exp_bclk);
    check("lrck", i2s_lrck, exp_lrck);
    check("sdata", i2s_sdata, exp_sdata);
    check("underrun", underrun, exp_underrun);
    check("ready", sample_ready, q.size() < DEPTH);
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) step(en, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("rst_bclk", i2s_bclk, 0);
    check("rst_lrck", i2s_lrck, 0);
    check("rst_sdata", i2s_sdata, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ready", sample_ready, 1);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_phase(input string tag, input int phase);
    for (int i = 0; i < 2 * FRAME && (t % FRAME) != phase; i++) step(1'b1, 1'b0, '0);
    check(tag, t % FRAME, phase);
  endtask

  initial begin
    int pulses;
    logic en_r;
    #2;
    do_reset();

    // One queued sample, then a full frame of 8001 on both channels.
    step(1'b0, 1'b1, 16'h8001);
    idle(300, 1'b1);

    // Fill the FIFO while running; ready drops on the fourth push.
    step(1'b1, 1'b1, 16'h7FFF);
    step(1'b1, 1'b1, 16'hA5A5);
    step(1'b1, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 16'hFFFF);
    check("full_after_4", sample_ready, 0);
    idle(700, 1'b1);

    // Starved: exactly one underrun pulse per 128-clk frame.
    pulses = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(1'b1, 1'b0, '0);
      if (underrun) pulses++;
    end
    check("underrun_per_frame", pulses, 3);

    // Push in the same clock as the frame load on an empty FIFO.
    wait_phase("sync_load", 3);
    step(1'b1, 1'b1, 16'h1234);
    check("coinc_underrun", underrun, 1);
    idle(FRAME + 10, 1'b1);

    // Drop enable in the R word, hold 50 clocks, then resume.
    step(1'b1, 1'b1, 16'h4C3B);
    step(1'b1, 1'b1, 16'h9E01);
    wait_phase("r_word_phase", 84);
    idle(50, 1'b0);
    check("hold_bclk", i2s_bclk, 0);
    check("hold_ready", sample_ready, 1);
    idle(300, 1'b1);

    // Randomised traffic with occasional enable toggles.
    en_r = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) en_r = ~en_r;
      step(en_r, $urandom_range(0, 9) == 0, SW'($urandom));
    end

    // Asynchronous reset mid-frame with samples queued.
    step(1'b1, 1'b1, 16'h5A5A);
    idle(37, 1'b1);
    do_reset();
    idle(20, 1'b0);
    step(1'b0, 1'b1, 16'hC001);
    idle(FRAME + 10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
